// File: rtl/zero_flag_scanner_pkg.sv
// zero_flag_pkg: shared state encoding and width helper for the zero/flag scanner.
// Rev 1.0
`default_nettype none

package zero_flag_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a count that must represent 0..w inclusive.
  function automatic int lzc_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/zero_flag_scanner_if.sv
// zero_flag_scanner_if: operand-in / flags-out valid-ready bundle.
// Rev 1.0
`default_nettype none

interface zero_flag_scanner_if
  import zero_flag_pkg::*;
#(
  parameter int WIDTH = 64
) ();
  localparam int LZW = lzc_width(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data;
  logic             out_valid;
  logic             out_ready;
  logic             zero;
  logic             negative;
  logic [LZW-1:0]   lzc;

  modport master (
    output in_valid, data, out_ready,
    input  in_ready, out_valid, zero, negative, lzc
  );

  modport slave (
    input  in_valid, data, out_ready,
    output in_ready, out_valid, zero, negative, lzc
  );

endinterface

`default_nettype wire

// File: rtl/zero_flag_scanner_chunk_lzc.sv
// chunk_lzc: combinational all-zero detect and leading-zero count of one chunk.
// Rev 1.0
`default_nettype none

module chunk_lzc #(
  parameter int CHUNK = 16,
  parameter int LZCW  = (CHUNK > 1) ? $clog2(CHUNK) : 1
) (
  input  wire logic [CHUNK-1:0] i_chunk,
  output logic                  o_all_zero,
  output logic [LZCW-1:0]       o_lz
);

  assign o_all_zero = ~|i_chunk;

  // Ascending scan so the highest set bit is the last (winning) assignment.
  always_comb begin
    o_lz = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (i_chunk[i]) o_lz = LZCW'(CHUNK - 1 - i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/zero_flag_scanner.sv
// zero_flag_scanner: multi-cycle chunked zero / negative / leading-zero-count flag unit.
// Rev 1.0
`default_nettype none

module zero_flag_scanner
  import zero_flag_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int CHUNK      = 16,
  parameter int EARLY_EXIT = 0
) (
  input  wire logic       clk,
  input  wire logic       reset,
  zero_flag_scanner_if.slave bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int LZW    = lzc_width(WIDTH);
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int CLZW   = (CHUNK > 1) ? $clog2(CHUNK) : 1;

  localparam logic [IDXW-1:0] C_IDX_TOP  = IDXW'(NCHUNK - 1);
  localparam logic [LZW-1:0]  C_LZC_ZERO = LZW'(WIDTH);

  state_t           r_state;
  logic [WIDTH-1:0] r_data;
  logic [IDXW-1:0]  r_idx;
  logic             r_found;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_zero;
  logic             r_negative;
  logic [LZW-1:0]   r_lzc;

  logic [CHUNK-1:0] w_chunk;
  logic             w_all_zero;
  logic [CLZW-1:0]  w_lz;
  logic [LZW-1:0]   w_lzc_cand;
  logic             w_hit;
  logic             w_last;

  assign w_chunk = r_data[r_idx*CHUNK +: CHUNK];

  chunk_lzc #(
    .CHUNK (CHUNK),
    .LZCW  (CLZW)
  ) u_chunk_lzc (
    .i_chunk    (w_chunk),
    .o_all_zero (w_all_zero),
    .o_lz       (w_lz)
  );

  // Only the first (most significant) nonzero chunk contributes to the count.
  assign w_hit      = !w_all_zero && !r_found;
  assign w_lzc_cand = LZW'((NCHUNK - 1 - int'(r_idx)) * CHUNK) + LZW'(w_lz);
  assign w_last     = (r_idx == '0) || ((EARLY_EXIT != 0) && w_hit);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_data      <= '0;
      r_idx       <= '0;
      r_found     <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_zero      <= 1'b0;
      r_negative  <= 1'b0;
      r_lzc       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_in_ready <= 1'b1;
          if (bus.in_valid && r_in_ready) begin
            r_data     <= bus.data;
            r_negative <= bus.data[WIDTH-1];
            r_idx      <= C_IDX_TOP;
            r_found    <= 1'b0;
            r_lzc      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= SCAN;
          end
        end
        SCAN: begin
          if (w_hit) begin
            r_lzc   <= w_lzc_cand;
            r_found <= 1'b1;
          end
          if (w_last) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            if (r_found || w_hit) begin
              r_zero <= 1'b0;
            end else begin
              r_zero <= 1'b1;
              r_lzc  <= C_LZC_ZERO;
            end
          end else begin
            r_idx <= r_idx - IDXW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.zero      = r_zero;
  assign bus.negative  = r_negative;
  assign bus.lzc       = r_lzc;

endmodule

`default_nettype wire

// File: doc/zero_flag_scanner.md
Name: zero_flag_scanner

Overview:
- Parametrised, multi-cycle successor to the 64-bit zero detector.
- Accepts a WIDTH-bit operand over a valid/ready handshake and scans it CHUNK bits per cycle, MSB chunk first.
- Returns zero, negative and leading-zero-count flags over a second valid/ready handshake.
- Sits after the ALU result register and feeds the flag register and the CLZ datapath.

Parameters:
- WIDTH, 64, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 16, bits examined per scan cycle; NCHUNK = WIDTH/CHUNK, NCHUNK >= 1.
- EARLY_EXIT, 0, if 1 the scan stops at the first nonzero chunk; if 0 latency is always NCHUNK.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- reset, input, 1, synchronous, active-low: reset==0 at a rising edge resets the block.
- in_valid, input, 1, operand present.
- in_ready, output, 1, block can accept an operand.
- data, input, WIDTH, operand; sampled only on the accept edge.
- out_valid, output, 1, result flags valid.
- out_ready, input, 1, consumer accepts the result.
- zero, output, 1, operand == 0.
- negative, output, 1, operand MSB (data[WIDTH-1]).
- lzc, output, $clog2(WIDTH+1), count of leading zeros; equals WIDTH when the operand is zero.

Behaviour:
- Reset (reset==0 at an edge):
  - State becomes IDLE.
  - out_valid=0, zero=0, negative=0, lzc=0.
  - Captured operand, chunk index and found flag are cleared.
  - in_ready is held 0 while reset is low.
- Reset mid-scan or mid-DONE aborts the operation. No out_valid is produced for the aborted operand.
- States:
  - IDLE:
    - in_ready=1.
    - On in_valid && in_ready: capture data, set negative=data[WIDTH-1], set idx=NCHUNK-1, found=0, acc=0, then go to SCAN.
  - SCAN:
    - in_ready=0.
    - Each cycle, examine chunk idx (bits idx*CHUNK+CHUNK-1 down to idx*CHUNK).
    - If the chunk is nonzero and found==0: set lzc=(NCHUNK-1-idx)*CHUNK + chunk_lz, then set found=1.
    - If idx==0, or (EARLY_EXIT && a nonzero chunk was found this cycle): go to DONE and set out_valid=1.
    - Otherwise decrement idx.
    - On leaving SCAN with found==0: zero=1 and lzc=WIDTH. Otherwise zero=0.
  - DONE:
    - out_valid=1; zero, negative and lzc are held stable.
    - On out_ready: out_valid=0 and go to IDLE.
    - in_ready=0, so there is no back-to-back acceptance in DONE.
- Latency, with accept at edge k:
  - EARLY_EXIT=0: out_valid rises after edge k+NCHUNK.
  - EARLY_EXIT=1: out_valid rises after edge k+1+(NCHUNK-1-i), where i is the index of the highest nonzero chunk. For a zero operand this is still NCHUNK.
- Throughput: at most one operand per (latency + 1) cycles.
- Width rules:
  - lzc arithmetic is unsigned, $clog2(WIDTH+1) bits, and never wraps.
  - chunk_lz ranges 0..CHUNK-1 on a nonzero chunk.
- NCHUNK==1: SCAN lasts exactly one cycle in both modes.
- data changes outside the accept edge are ignored.
- in_valid asserted during SCAN or DONE is ignored, not queued. The producer holds in_valid until in_ready.
- All outputs are registered; none is combinational from data.

Decomposition:
- Package zero_flag_pkg:
  - state enum {IDLE, SCAN, DONE}.
  - Function computing the lzc width, $clog2(WIDTH+1).
- Sub-module chunk_lzc:
  - Combinational, parameter CHUNK.
  - Input CHUNK bits; outputs all_zero and lz ($clog2(CHUNK) bits, leading-zero count).
  - all_zero is the generalised replacement for the fixed 64-bit NOR/AND tree.
  - One instance is muxed by idx.

Test Plan (WIDTH=64, CHUNK=16, both EARLY_EXIT values unless noted):
- data=64'd0 -> zero=1, negative=0, lzc=64; out_valid 4 cycles after accept in both modes.
- data=64'd1 -> zero=0, negative=0, lzc=63. Latency 4 for EARLY_EXIT=0 and 4 for EARLY_EXIT=1.
- data=64'd4390270857 (highest set bit 32) -> zero=0, lzc=31. Latency 4 for EARLY_EXIT=0 and 2 for EARLY_EXIT=1.
- data=64'h8000_0000_0000_0000 -> negative=1, lzc=0, zero=0. Latency 1 for EARLY_EXIT=1.
- Hold out_ready=0 for 5 cycles after out_valid -> out_valid, zero, negative and lzc stay stable; in_ready=0; an in_valid pulse is ignored. After out_ready=1, in_ready returns to 1 the next cycle.
- Drive reset=0 for one edge during SCAN of data=1 -> out_valid never rises for that operand; all outputs read 0; in_ready=1 after reset returns high. The next operand 64'd0 yields lzc=64.
